uart_io_queue: RTL and testbench

Parametrised byte-stream I/O buffer between the execute stage and the UART PHY (uart_rx/uart_tx byte interfaces).
- Holds separate RX and TX circular queues in inferred RAM with a configurable read latency.
- Serves IN/OUT instructions of 1–4 bytes, assembled/split little-endian.
- Sends a one-time sync byte for the loader handshake, tracks occupancy and flags RX overflow.

---
 rtl/uart_io_queue.sv | 227 ++++++++++++++++++++++
 tb/tb_uart_io_queue.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_io_queue.sv
// Byte-stream I/O buffer between the execute stage and the UART PHY.
// Holds separate RX and TX circular byte queues with a pipelined RAM read.
// It assembles IN results and splits OUT words little-endian, sends a
// one-time sync byte, and flags RX overflow.

// Circular byte queue in inferred RAM. Read data appears RD_LAT cycles
// after the pop, taken from head at the time of the pop.
module uart_io_queue_fifo #(
  parameter int DEPTH_LOG2 = 11,
  parameter int RD_LAT     = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  push_i,
  input  logic [7:0]            wdata_i,
  input  logic                  pop_i,
  output logic [7:0]            rdata_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic [DEPTH_LOG2:0]   count_o
);
  localparam int SIZE = 2 ** DEPTH_LOG2;

  logic [7:0]            mem_q  [SIZE];
  logic [7:0]            pipe_q [RD_LAT];
  logic [DEPTH_LOG2-1:0] head_q, tail_q, tail_inc;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  do_push, do_pop;

  assign tail_inc = tail_q + DEPTH_LOG2'(1);
  assign empty_o  = (head_q == tail_q);
  assign full_o   = (tail_inc == head_q);
  assign do_push  = push_i && !full_o;
  assign do_pop   = pop_i && !empty_o;
  assign rdata_o  = pipe_q[RD_LAT-1];
  assign count_o  = count_q;

  // Pointer and occupancy update; push and pop in one cycle cancel out.
  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) tail_q <= tail_inc;
      if (do_pop)  head_q <= head_q + DEPTH_LOG2'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (DEPTH_LOG2 + 1)'(1);
        2'b01:   count_q <= count_q - (DEPTH_LOG2 + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage write and read pipeline; head is read every cycle.
  // NOTE: the RAM and its read pipeline are deliberately not reset so they
  // map onto block RAM; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[tail_q] <= wdata_i;
    pipe_q[0] <= mem_q[head_q];
    for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
  end
endmodule

module uart_io_queue #(
  parameter int           DEPTH_LOG2 = 11,
  parameter int           RD_LAT     = 2,
  parameter logic [7:0]   SYNC_BYTE  = 8'hAA
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [7:0]          rx_byte,
  input  logic                rx_valid,
  output logic [7:0]          tx_byte,
  output logic                tx_start,
  input  logic                tx_busy,
  input  logic                sync_en,
  output logic                sync_done,
  output logic                sync_seen,
  input  logic                rx_accept,
  input  logic                req,
  input  logic                req_out,
  input  logic [1:0]          nbytes,
  input  logic [31:0]         wdata,
  output logic                busy,
  output logic                done,
  output logic [31:0]         rdata,
  output logic [DEPTH_LOG2:0] rx_count,
  output logic [DEPTH_LOG2:0] tx_count,
  output logic                rx_overflow
);
  localparam logic [2:0] ST_IDLE = 3'd0, ST_IN_POP = 3'd1, ST_IN_WAIT = 3'd2,
                         ST_OUT_PUSH = 3'd3, ST_FIN = 3'd4;
  localparam logic [1:0] D_IDLE = 2'd0, D_WAIT = 2'd1, D_START = 2'd2, D_GUARD = 2'd3;
  localparam logic [1:0] S_IDLE = 2'd0, S_START = 2'd1, S_GUARD = 2'd2, S_WAIT = 2'd3;
  localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

  logic [2:0]  state_q, state_d;
  logic [1:0]  drain_q, drain_d, sync_q, sync_d;
  logic [1:0]  k_q, nbytes_q, lat_q, dlat_q;
  logic [31:0] wdata_q, asm_q, asm_d, rdata_q;
  logic [7:0]  tx_byte_q, rx_rdata, tx_rdata;
  logic        sync_done_q, sync_seen_q, overflow_q;
  logic        rx_empty, rx_full, tx_empty, tx_full;
  logic        rx_push, rx_pop, tx_push, tx_pop, sync_block, sync_go;

  assign rx_push    = rx_valid && rx_accept && !rx_full;
  assign rx_pop     = (state_q == ST_IN_POP) && !rx_empty;
  assign tx_push    = (state_q == ST_OUT_PUSH) && !tx_full;
  assign sync_block = sync_en && !sync_done_q;
  assign tx_pop     = (drain_q == D_IDLE) && (sync_q == S_IDLE) && !tx_busy &&
                      !tx_empty && !sync_block;
  assign sync_go    = (sync_q == S_IDLE) && sync_block && (drain_q == D_IDLE) && !tx_busy;

  uart_io_queue_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .RD_LAT(RD_LAT)) u_rx_q (
    .clk(clk), .rstn(rstn), .push_i(rx_push), .wdata_i(rx_byte), .pop_i(rx_pop),
    .rdata_o(rx_rdata), .empty_o(rx_empty), .full_o(rx_full), .count_o(rx_count)
  );

  uart_io_queue_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .RD_LAT(RD_LAT)) u_tx_q (
    .clk(clk), .rstn(rstn), .push_i(tx_push), .wdata_i(wdata_q[8*k_q +: 8]), .pop_i(tx_pop),
    .rdata_o(tx_rdata), .empty_o(tx_empty), .full_o(tx_full), .count_o(tx_count)
  );

  // Next state of the IN/OUT sequencer and the assembled IN word.
  // NOTE: every output of an always_comb gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    asm_d   = asm_q;
    asm_d[8*k_q +: 8] = rx_rdata;
    case (state_q)
      ST_IDLE:     if (req) state_d = req_out ? ST_OUT_PUSH : ST_IN_POP;
      ST_IN_POP:   if (!rx_empty) state_d = ST_IN_WAIT;
      ST_IN_WAIT:  if (lat_q == 2'd0) state_d = (k_q == nbytes_q) ? ST_FIN : ST_IN_POP;
      ST_OUT_PUSH: if (!tx_full && (k_q == nbytes_q)) state_d = ST_FIN;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Next state of the TX drain and the one-time sync sender.
  always_comb begin
    drain_d = drain_q;
    sync_d  = sync_q;
    case (drain_q)
      D_IDLE:  if (tx_pop) drain_d = D_WAIT;
      D_WAIT:  if (dlat_q == 2'd0) drain_d = D_START;
      D_START: drain_d = D_GUARD;
      default: drain_d = D_IDLE;
    endcase
    case (sync_q)
      S_IDLE:  if (sync_go) sync_d = S_START;
      S_START: sync_d = S_GUARD;
      S_GUARD: sync_d = S_WAIT;
      default: if (!tx_busy) sync_d = S_IDLE;
    endcase
  end

  // Sequencer registers: request latch, byte index, read-latency count, result.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      k_q      <= '0;
      nbytes_q <= '0;
      lat_q    <= '0;
      wdata_q  <= '0;
      asm_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: if (req) begin
          nbytes_q <= nbytes;
          wdata_q  <= wdata;
          k_q      <= '0;
          asm_q    <= '0;
        end
        ST_IN_POP: if (!rx_empty) lat_q <= LAT_INIT;
        ST_IN_WAIT: begin
          if (lat_q == 2'd0) begin
            asm_q <= asm_d;
            k_q   <= k_q + 2'd1;
            if (k_q == nbytes_q) rdata_q <= asm_d;
          end else begin
            lat_q <= lat_q - 2'd1;
          end
        end
        ST_OUT_PUSH: if (!tx_full) k_q <= k_q + 2'd1;
        default: ;
      endcase
    end
  end

  // Drain/sync registers, shared tx_byte, and the RX status flags.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      drain_q     <= D_IDLE;
      sync_q      <= S_IDLE;
      dlat_q      <= '0;
      tx_byte_q   <= '0;
      sync_done_q <= 1'b0;
      sync_seen_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      drain_q <= drain_d;
      sync_q  <= sync_d;
      if (tx_pop) dlat_q <= LAT_INIT;
      else if (drain_q == D_WAIT && dlat_q != 2'd0) dlat_q <= dlat_q - 2'd1;
      if (sync_go) tx_byte_q <= SYNC_BYTE;
      else if (drain_q == D_WAIT && dlat_q == 2'd0) tx_byte_q <= tx_rdata;
      if (sync_q == S_WAIT && !tx_busy) sync_done_q <= 1'b1;
      sync_seen_q <= rx_valid && (rx_byte == SYNC_BYTE);
      if (rx_valid && rx_accept && rx_full) overflow_q <= 1'b1;
    end
  end

  assign busy        = (req && state_q == ST_IDLE) || (state_q != ST_IDLE);
  assign done        = (state_q == ST_FIN);
  assign rdata       = rdata_q;
  assign tx_byte     = tx_byte_q;
  assign tx_start    = (drain_q == D_START) || (sync_q == S_START);
  assign sync_done   = sync_done_q;
  assign sync_seen   = sync_seen_q;
  assign rx_overflow = overflow_q;
endmodule

// File: tb/tb_uart_io_queue.sv
// Scoreboard bench for uart_io_queue: stimulus pushes expected done pulses
// and TX bytes into queues; monitors pop and compare on the falling edge.
module tb_uart_io_queue;
  localparam int         DL = 11;
  localparam int         RL = 2;
  localparam logic [7:0] SB = 8'hAA;

  logic          clk = 1'b0;
  logic          rstn;
  logic [7:0]    rx_byte;
  logic          rx_valid;
  logic [7:0]    tx_byte;
  logic          tx_start;
  logic          tx_busy;
  logic          sync_en;
  logic          sync_done;
  logic          sync_seen;
  logic          rx_accept;
  logic          req;
  logic          req_out;
  logic [1:0]    nbytes;
  logic [31:0]   wdata;
  logic          busy;
  logic          done;
  logic [31:0]   rdata;
  logic [DL:0]   rx_count;
  logic [DL:0]   tx_count;
  logic          rx_overflow;

  uart_io_queue #(.DEPTH_LOG2(DL), .RD_LAT(RL), .SYNC_BYTE(SB)) dut (
    .clk(clk), .rstn(rstn), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .tx_byte(tx_byte), .tx_start(tx_start), .tx_busy(tx_busy),
    .sync_en(sync_en), .sync_done(sync_done), .sync_seen(sync_seen),
    .rx_accept(rx_accept), .req(req), .req_out(req_out), .nbytes(nbytes),
    .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .rx_count(rx_count), .tx_count(tx_count), .rx_overflow(rx_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_in;
    logic [31:0] rd;
    int          at;
  } done_exp_t;

  done_exp_t  done_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] model_q[$];
  done_exp_t  mon_e;
  logic [7:0] mon_b;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  int         last_start = -1000;
  int         busy_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // uart_tx model: busy for 10 cycles after each start strobe
  always @(posedge clk) begin
    if (!rstn)         busy_cnt <= 0;
    else if (tx_start) busy_cnt <= 10;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: done pulses and TX start strobes against the scoreboards
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (done) begin
        if (done_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
        end else begin
          mon_e = done_q.pop_front();
          check("done_cycle", cyc, mon_e.at);
          if (mon_e.is_in) check("in_rdata", rdata, mon_e.rd);
        end
      end
      if (tx_start) begin
        check("tx_start_while_busy", {31'd0, tx_busy}, 32'd0);
        if (tx_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_tx_start: got byte 0x%02h expected none (cycle %0d)", tx_byte, cyc);
        end else begin
          mon_b = tx_q.pop_front();
          check("tx_byte", {24'd0, tx_byte}, {24'd0, mon_b});
        end
        last_start = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic expect_done(input logic is_in, input logic [31:0] rd, input int at);
    done_exp_t e;
    e.is_in = is_in; e.rd = rd; e.at = at;
    done_q.push_back(e);
  endtask

  task automatic issue(input logic is_out, input logic [1:0] n, input logic [31:0] wd);
    req = 1'b1; req_out = is_out; nbytes = n; wdata = wd;
    #1;
    check("busy_on_req", {31'd0, busy}, 32'd1);
    tick();
    req = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while (done_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    if (done_q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL %s: timeout, got %0d done pulses outstanding expected 0", name, done_q.size());
      done_q.delete();
    end
  endtask

  task automatic wait_tx(input string name, input int budget);
    int k = 0;
    while (tx_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    if (tx_q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL %s: timeout, got %0d tx bytes outstanding expected 0", name, tx_q.size());
      tx_q.delete();
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int k;
    logic [7:0]  b;
    logic [31:0] val;
    int n;

    rstn = 1'b0; rx_byte = '0; rx_valid = 1'b0; sync_en = 1'b0; rx_accept = 1'b0;
    req = 1'b0; req_out = 1'b0; nbytes = '0; wdata = '0;
    repeat (3) tick();

    // Reset values
    check("rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("rst_tx_byte", {24'd0, tx_byte}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_sync_done", {31'd0, sync_done}, 32'd0);
    check("rst_sync_seen", {31'd0, sync_seen}, 32'd0);
    check("rst_overflow", {31'd0, rx_overflow}, 32'd0);
    check("rst_rx_count", 32'(rx_count), 32'd0);
    check("rst_tx_count", 32'(tx_count), 32'd0);
    rstn = 1'b1;
    tick();

    // Sync handshake: exactly one SYNC_BYTE start, done after busy falls
    tx_q.push_back(SB);
    sync_en = 1'b1;
    k = 0;
    while (!sync_done && k < 100) begin tick(); k++; end
    check("sync_done_set", {31'd0, sync_done}, 32'd1);
    check("sync_start_seen", tx_q.size(), 32'd0);
    check("sync_after_busy", {31'd0, (cyc - last_start) >= 11}, 32'd1);
    repeat (30) tick();
    check("sync_done_sticky", {31'd0, sync_done}, 32'd1);

    // sync_seen pulses even with rx_accept low; byte is not captured
    send_rx(SB);
    check("sync_seen_pulse", {31'd0, sync_seen}, 32'd1);
    check("ignored_rx_count", 32'(rx_count), 32'd0);
    tick();
    check("sync_seen_clear", {31'd0, sync_seen}, 32'd0);

    // IN of 4 bytes, little-endian assembly at minimum latency
    rx_accept = 1'b1;
    send_rx(8'h11); send_rx(8'h22); send_rx(8'h33); send_rx(8'h44);
    check("rx_count_4", 32'(rx_count), 32'd4);
    c0 = cyc;
    expect_done(1'b1, 32'h44332211, c0 + 4 * (RL + 1) + 1);
    issue(1'b0, 2'd3, 32'd0);
    wait_done("in4_done", 100);
    check("rx_count_after_in4", 32'(rx_count), 32'd0);

    // IN of 1 byte on an empty queue stalls until the byte arrives
    issue(1'b0, 2'd0, 32'd0);
    check("busy_held_start", {31'd0, busy}, 32'd1);
    repeat (20) tick();
    check("busy_held_20", {31'd0, busy}, 32'd1);
    c0 = cyc;
    expect_done(1'b1, 32'h0000005A, c0 + RL + 2);
    send_rx(8'h5A);
    wait_done("in1_done", 100);

    // OUT of 2 bytes: EF then BE on the wire
    tx_q.push_back(8'hEF);
    tx_q.push_back(8'hBE);
    c0 = cyc;
    expect_done(1'b0, 32'd0, c0 + 3);
    issue(1'b1, 2'd1, 32'hDEADBEEF);
    wait_done("out_done", 100);
    wait_tx("out_tx", 200);
    repeat (3) tick();
    check("tx_count_drained", 32'(tx_count), 32'd0);
    check("rdata_held", rdata, 32'h0000005A);

    // Fill RX to capacity across the pointer wrap, then overflow once
    for (int i = 0; i < (2 ** DL) - 1; i++) begin
      b = 8'(i * 7 + 3);
      model_q.push_back(b);
      send_rx(b);
    end
    check("rx_full_count", 32'(rx_count), 32'((2 ** DL) - 1));
    check("no_overflow_yet", {31'd0, rx_overflow}, 32'd0);
    send_rx(8'hFF);
    check("overflow_set", {31'd0, rx_overflow}, 32'd1);
    check("overflow_count", 32'(rx_count), 32'((2 ** DL) - 1));
    while (model_q.size() > 0) begin
      n   = (model_q.size() >= 4) ? 4 : model_q.size();
      val = '0;
      for (int j = 0; j < n; j++) val[8*j +: 8] = model_q.pop_front();
      c0 = cyc;
      expect_done(1'b1, val, c0 + n * (RL + 1) + 1);
      issue(1'b0, 2'(n - 1), 32'd0);
      wait_done("drain_in_done", 100);
    end
    check("rx_empty_after_drain", 32'(rx_count), 32'd0);
    check("overflow_sticky", {31'd0, rx_overflow}, 32'd1);

    // Reset during IN_WAIT abandons the operation without done
    sync_en = 1'b0;
    send_rx(8'h77); send_rx(8'h78);
    issue(1'b0, 2'd0, 32'd0);
    tick();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_rx_count", 32'(rx_count), 32'd0);
    check("midrst_tx_count", 32'(tx_count), 32'd0);
    check("midrst_rdata", rdata, 32'd0);
    check("midrst_overflow", {31'd0, rx_overflow}, 32'd0);
    repeat (10) tick();

    // A fresh IN after reset behaves normally
    send_rx(8'h01); send_rx(8'h02);
    c0 = cyc;
    expect_done(1'b1, 32'h00000201, c0 + 2 * (RL + 1) + 1);
    issue(1'b0, 2'd1, 32'd0);
    wait_done("post_rst_in", 100);
    check("post_rst_rx_count", 32'(rx_count), 32'd0);
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
